// File: rtl/stage_sequencer.sv
// stage_sequencer: multi-cycle LEGv8 control sequencer. A single clock drives
// registered one-hot stage enables (fetch/decode/execute/memory/write-back).
// It also resolves branches into pc_src, times out a stalled memory handshake
// and counts retired instructions.
module stage_sequencer #(
  parameter int DECODE_CYCLES = 1,
  parameter int EXEC_CYCLES   = 1,
  parameter int MEM_WAIT_MAX  = 15,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             halt,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             branch,
  input  logic             uncond_branch,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             exec_en,
  output logic             mem_en,
  output logic             wb_en,
  output logic             pc_src,
  output logic             busy,
  output logic             mem_timeout,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  // Counter widths: each counter only reaches (limit - 1) before leaving its state.
  localparam int DW = (DECODE_CYCLES > 1) ? $clog2(DECODE_CYCLES) : 1;
  localparam int EW = (EXEC_CYCLES   > 1) ? $clog2(EXEC_CYCLES)   : 1;
  localparam int WW = (MEM_WAIT_MAX  > 1) ? $clog2(MEM_WAIT_MAX)  : 1;

  logic [DW-1:0]    dec_cnt;
  logic [EW-1:0]    exe_cnt;
  logic [WW-1:0]    wait_cnt;
  logic             cls_load, cls_store, cls_br, cls_ub;
  logic             dec_last, exe_last, wait_last, retire;
  logic [2:0]       state_nx;
  logic             fetch_nx, decode_nx, exec_nx, mem_nx, wb_nx;
  logic             pc_src_nx, busy_nx, timeout_nx;
  logic [CNT_W-1:0] retired_nx;

  assign dec_last  = (int'(dec_cnt) == DECODE_CYCLES - 1);
  assign exe_last  = (int'(exe_cnt) == EXEC_CYCLES - 1);
  assign wait_last = (MEM_WAIT_MAX > 0) && (int'(wait_cnt) == MEM_WAIT_MAX - 1);
  // Retire is the exit from WB, or a MEM completion that needs no write-back.
  assign retire    = (state == S_WB) || ((state == S_MEM) && mem_ready && !cls_load);

  // State and registered Moore outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      fetch_en    <= 1'b0;
      decode_en   <= 1'b0;
      exec_en     <= 1'b0;
      mem_en      <= 1'b0;
      wb_en       <= 1'b0;
      pc_src      <= 1'b0;
      busy        <= 1'b0;
      mem_timeout <= 1'b0;
      retired     <= '0;
    end else begin
      state       <= state_nx;
      fetch_en    <= fetch_nx;
      decode_en   <= decode_nx;
      exec_en     <= exec_nx;
      mem_en      <= mem_nx;
      wb_en       <= wb_nx;
      pc_src      <= pc_src_nx;
      busy        <= busy_nx;
      mem_timeout <= timeout_nx;
      retired     <= retired_nx;
    end
  end

  // Stage dwell counters, memory wait counter and instruction-class latch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dec_cnt   <= '0;
      exe_cnt   <= '0;
      wait_cnt  <= '0;
      cls_load  <= 1'b0;
      cls_store <= 1'b0;
      cls_br    <= 1'b0;
      cls_ub    <= 1'b0;
    end else begin
      dec_cnt <= ((state == S_DECODE) && !dec_last) ? dec_cnt + DW'(1) : '0;
      exe_cnt <= ((state == S_EXEC) && !exe_last) ? exe_cnt + EW'(1) : '0;
      if (state != S_MEM)
        wait_cnt <= '0;
      else if (!mem_ready && (MEM_WAIT_MAX > 0))
        wait_cnt <= wait_cnt + WW'(1);
      if ((state == S_DECODE) && dec_last) begin
        cls_load  <= is_load;
        cls_store <= is_store;
        cls_br    <= branch;
        cls_ub    <= uncond_branch;
      end
    end
  end

  // Next-state selection
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (run) state_nx = S_FETCH;
      S_FETCH:  state_nx = S_DECODE;
      S_DECODE: if (dec_last) state_nx = S_EXEC;
      S_EXEC:   if (exe_last)
                  state_nx = (cls_load | cls_store | cls_br | cls_ub) ? S_MEM : S_WB;
      S_MEM:    if (mem_ready)
                  state_nx = cls_load ? S_WB : (halt ? S_IDLE : S_FETCH);
                else if (wait_last)
                  state_nx = S_ERR;
      S_WB:     state_nx = halt ? S_IDLE : S_FETCH;
      S_ERR:    state_nx = S_ERR;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Output values for the next cycle, decoded from the next state
  always_comb begin
    fetch_nx   = (state_nx == S_FETCH);
    decode_nx  = (state_nx == S_DECODE);
    exec_nx    = (state_nx == S_EXEC);
    mem_nx     = (state_nx == S_MEM);
    wb_nx      = (state_nx == S_WB);
    busy_nx    = (state_nx != S_IDLE) && (state_nx != S_ERR);
    timeout_nx = mem_timeout | (state_nx == S_ERR);
    retired_nx = retired + CNT_W'(retire);
    pc_src_nx  = pc_src;
    // The fetch consumes pc_src; a completing MEM cycle resolves the branch.
    if (state == S_FETCH)
      pc_src_nx = 1'b0;
    else if ((state == S_MEM) && mem_ready)
      pc_src_nx = cls_ub | (cls_br & zero);
  end

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboard bench for stage_sequencer: each driven cycle pushes the expected
// post-edge observation; a monitor pops and compares just after each edge.
module tb_stage_sequencer;

  localparam int DEC = 3;
  localparam int EXE = 2;
  localparam int MWM = 4;
  localparam int CW  = 4;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  localparam int K_ALU = 0, K_LD = 1, K_ST = 2, K_BR = 3, K_UB = 4;

  logic clk = 1'b0;
  logic reset, run, halt, is_load, is_store, branch, uncond_branch, zero, mem_ready;
  logic fetch_en, decode_en, exec_en, mem_en, wb_en, pc_src, busy, mem_timeout;
  logic [2:0] state;
  logic [CW-1:0] retired;

  typedef struct packed {
    logic [2:0] st;
    logic       pc;
    logic       to;
    logic [3:0] ret;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   m_ret = 0;
  logic m_pc  = 1'b0;
  logic m_to  = 1'b0;

  stage_sequencer #(
    .DECODE_CYCLES(DEC), .EXEC_CYCLES(EXE), .MEM_WAIT_MAX(MWM), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .halt(halt),
    .is_load(is_load), .is_store(is_store), .branch(branch),
    .uncond_branch(uncond_branch), .zero(zero), .mem_ready(mem_ready),
    .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en),
    .mem_en(mem_en), .wb_en(wb_en), .pc_src(pc_src), .busy(busy),
    .mem_timeout(mem_timeout), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Push the observation expected after the coming edge, then move to the next negedge.
  task automatic tick(input logic [2:0] st);
    exp_t e;
    e.st  = st;
    e.pc  = m_pc;
    e.to  = m_to;
    e.ret = 4'(m_ret);
    sb.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: compare the DUT just after each rising edge
  initial begin
    exp_t e;
    logic [4:0] en_exp;
    logic       busy_exp;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e        = sb.pop_front();
        en_exp   = {e.st == S_FETCH, e.st == S_DECODE, e.st == S_EXEC,
                    e.st == S_MEM, e.st == S_WB};
        busy_exp = (e.st != S_IDLE) && (e.st != S_ERR);
        chk("state", 32'(state), 32'(e.st));
        chk("outs", 32'({fetch_en, decode_en, exec_en, mem_en, wb_en, pc_src,
                         busy, mem_timeout, retired}),
                    32'({en_exp, e.pc, busy_exp, e.to, e.ret}));
      end
    end
  end

  task automatic start();
    run = 1'b1;
    tick(S_FETCH);
    run = 1'b0;
  endtask

  // One instruction, entered with the DUT in FETCH; ends on the retire edge.
  task automatic instr(input int kind, input int nwait, input logic z, input logic hlt);
    is_load       = (kind == K_LD);
    is_store      = (kind == K_ST);
    branch        = (kind == K_BR);
    uncond_branch = (kind == K_UB);
    zero          = ~z;
    halt          = 1'b1;
    mem_ready     = 1'($urandom);
    run           = 1'b1;
    m_pc          = 1'b0;
    for (int i = 0; i < DEC; i++) tick(S_DECODE);
    for (int i = 0; i < EXE; i++) begin
      tick(S_EXEC);
      if (i == 0) {is_load, is_store, branch, uncond_branch} = 4'($urandom);
    end
    if (kind == K_ALU) begin
      tick(S_WB);
    end else begin
      mem_ready = 1'b0;
      tick(S_MEM);
      for (int w = 0; w < nwait; w++) begin
        mem_ready = 1'b0;
        zero      = 1'($urandom);
        if (w == MWM - 1) begin
          m_to = 1'b1;
          tick(S_ERR);
          halt = 1'b0;
          run  = 1'b0;
          return;
        end
        tick(S_MEM);
      end
      mem_ready = 1'b1;
      zero      = z;
      if (kind == K_BR) m_pc = z;
      if (kind == K_UB) m_pc = 1'b1;
      if (kind == K_LD) tick(S_WB);
    end
    m_ret++;
    halt = hlt;
    tick(hlt ? S_IDLE : S_FETCH);
    halt      = 1'b0;
    run       = 1'b0;
    mem_ready = 1'b0;
  endtask

  // Asynchronous reset from a negedge; checks outputs before any clock edge.
  task automatic async_reset();
    reset = 1'b1;
    #1;
    chk("rst_state", 32'(state), 32'(S_IDLE));
    chk("rst_outs", 32'({fetch_en, decode_en, exec_en, mem_en, wb_en, pc_src,
                         busy, mem_timeout}), 32'(0));
    chk("rst_retired", 32'(retired), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    m_ret = 0;
    m_pc  = 1'b0;
    m_to  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; run = 1'b0; halt = 1'b0; is_load = 1'b0; is_store = 1'b0;
    branch = 1'b0; uncond_branch = 1'b0; zero = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    async_reset();

    // Idle with halt noise and no run
    halt = 1'b1;
    tick(S_IDLE);
    tick(S_IDLE);
    halt = 1'b0;

    // ALU, load with 3 waits, taken/not-taken/unconditional branches, store then halt
    start();
    instr(K_ALU, 0, 1'b0, 1'b0);
    instr(K_LD,  3, 1'b0, 1'b0);
    instr(K_BR,  0, 1'b1, 1'b0);
    instr(K_BR,  0, 1'b0, 1'b0);
    instr(K_UB,  1, 1'b0, 1'b0);
    instr(K_ST,  MWM - 1, 1'b0, 1'b1);
    tick(S_IDLE);

    // Counter wrap: 17 back-to-back ALU ops, halt on the last retire
    async_reset();
    start();
    for (int n = 0; n < 17; n++) instr(K_ALU, 0, 1'b0, (n == 16));
    tick(S_IDLE);

    // Reset in the middle of EXEC
    start();
    is_load = 1'b0; is_store = 1'b0; branch = 1'b0; uncond_branch = 1'b0;
    for (int i = 0; i < DEC; i++) tick(S_DECODE);
    tick(S_EXEC);
    async_reset();

    // Store that never sees mem_ready: timeout, then run is ignored
    start();
    instr(K_ST, 10, 1'b0, 1'b0);
    run = 1'b1;
    tick(S_ERR);
    tick(S_ERR);
    run = 1'b0;
    tick(S_ERR);

    @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
